blit_write_buffer: RTL and testbench

BLIT_WRITE_BUFFER -- requirements
Module: blit_write_buffer

---
 rtl/blit_pkg.sv | 31 +++
 rtl/blit_wbuf_mem.sv | 32 +++
 rtl/blit_write_buffer.sv | 145 ++++++++++++++
 tb/tb_blit_write_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared blitter/SDRAM types: address width and the buffered write record.
// Reused by the write buffer, the SDRAM arbiter and blit_top.
package blit_pkg;

    localparam int SDRAM_ADDR_W = 26;
    localparam int SDRAM_DATA_W = 32;
    localparam int SDRAM_BE_W   = 4;

    typedef struct packed {
        logic [SDRAM_ADDR_W-1:0] addr;
        logic [SDRAM_DATA_W-1:0] wdata;
        logic [SDRAM_BE_W-1:0]   byte_enable;
    } blit_wr_t;

    // Replace the byte lanes selected by 'lanes' in old_d with those of new_d.
    function automatic logic [SDRAM_DATA_W-1:0] merge_lanes(
        input logic [SDRAM_DATA_W-1:0] old_d,
        input logic [SDRAM_DATA_W-1:0] new_d,
        input logic [SDRAM_BE_W-1:0]   lanes
    );
        logic [SDRAM_DATA_W-1:0] r;
        r = old_d;
        for (int n = 0; n < SDRAM_BE_W; n++) begin
            if (lanes[n]) begin
                r[8*n +: 8] = new_d[8*n +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/blit_wbuf_mem.sv
// Write-buffer storage: DEPTH x blit_wr_t, one write port with per-lane data
// write (used when merging into the tail), one asynchronous read port.
module blit_wbuf_mem
    import blit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic           clock,
    input  logic           we_i,
    input  logic [AW-1:0]  waddr_i,
    input  logic [3:0]     wlane_i,
    input  blit_wr_t       wentry_i,
    input  logic [AW-1:0]  raddr_i,
    output blit_wr_t       rentry_o
);

    blit_wr_t mem_q [DEPTH];

    // Entry write: addr and byte_enable replaced whole, data only on selected lanes.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i].addr        <= wentry_i.addr;
            mem_q[waddr_i].byte_enable <= wentry_i.byte_enable;
            mem_q[waddr_i].wdata       <= merge_lanes(mem_q[waddr_i].wdata,
                                                      wentry_i.wdata, wlane_i);
        end
    end

    assign rentry_o = mem_q[raddr_i];

endmodule

// File: rtl/blit_write_buffer.sv
// Blitter write buffer: FIFO of SDRAM writes between the blitter and
// sdram_arbiter bus4. Zero-enable writes are dropped.
// Optional feature: define BLIT_WRITE_BUFFER_MERGE_EN to merge a write into the
// tail entry when it hits the same address and the tail is not the presented head.
module blit_write_buffer
    import blit_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SDRAM_ADDR_W-1:0] in_addr,
    input  logic [31:0]             in_wdata,
    input  logic [3:0]              in_byte_enable,
    output logic                    pending,
    output logic                    blitw_sdram_req,
    output logic [SDRAM_ADDR_W-1:0] blitw_sdram_addr,
    output logic [31:0]             blitw_sdram_wdata,
    output logic [3:0]              blitw_sdram_byte_enable,
    input  logic                    blitw_sdram_ack
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

`ifdef BLIT_WRITE_BUFFER_MERGE_EN
    localparam bit MERGE_EN = 1'b1;
`else
    localparam bit MERGE_EN = 1'b0;
`endif

    logic [CW-1:0]           count_q, count_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic                    ready_en_q;
    logic [SDRAM_ADDR_W-1:0] tail_addr_q, tail_addr_d;
    logic [3:0]              tail_be_q, tail_be_d;

    logic                    not_empty;
    logic                    not_full;
    logic                    merge_hit;
    logic                    accept;
    logic                    do_merge;
    logic                    do_push;
    logic                    do_pop;

    logic                    mem_we;
    logic [AW-1:0]           mem_waddr;
    logic [3:0]              mem_wlane;
    blit_wr_t                mem_wentry;
    blit_wr_t                head;

    // Handshake qualification; the ack only affects state, never in_ready.
    always_comb begin
        not_empty = (count_q != '0);
        not_full  = (count_q != CW'(DEPTH));
        merge_hit = MERGE_EN && (count_q >= CW'(2)) && (in_addr == tail_addr_q);
        in_ready  = ready_en_q && (not_full || merge_hit);
        accept    = in_valid && in_ready && (in_byte_enable != 4'b0000);
        do_merge  = accept && merge_hit;
        do_push   = accept && !merge_hit;
        do_pop    = blitw_sdram_ack && not_empty;
    end

    // Next-state for pointers, occupancy and the tail shadow used for merge compare.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        tail_addr_d = tail_addr_q;
        tail_be_d   = tail_be_q;

        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push) begin
            wr_ptr_d    = wr_ptr_q + AW'(1);
            tail_addr_d = in_addr;
            tail_be_d   = in_byte_enable;
        end else if (do_merge) begin
            tail_be_d   = tail_be_q | in_byte_enable;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage write: a fresh entry writes all lanes, a merge only the enabled ones.
    always_comb begin
        mem_we     = do_push || do_merge;
        mem_waddr  = do_merge ? (wr_ptr_q - AW'(1)) : wr_ptr_q;
        mem_wlane  = do_merge ? in_byte_enable : 4'hF;
        mem_wentry = '{addr:        in_addr,
                       wdata:       in_wdata,
                       byte_enable: do_merge ? (tail_be_q | in_byte_enable)
                                             : in_byte_enable};
    end

    // Control state register; ready_en_q holds in_ready low until the first edge out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            ready_en_q  <= 1'b0;
            tail_addr_q <= '0;
            tail_be_q   <= '0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            ready_en_q  <= 1'b1;
            tail_addr_q <= tail_addr_d;
            tail_be_q   <= tail_be_d;
        end
    end

    blit_wbuf_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock    (clock),
        .we_i     (mem_we),
        .waddr_i  (mem_waddr),
        .wlane_i  (mem_wlane),
        .wentry_i (mem_wentry),
        .raddr_i  (rd_ptr_q),
        .rentry_o (head)
    );

    // Head fields are forced to zero when nothing is buffered (and therefore in reset).
    always_comb begin
        blitw_sdram_req         = not_empty;
        pending                 = not_empty;
        blitw_sdram_addr        = not_empty ? head.addr        : '0;
        blitw_sdram_wdata       = not_empty ? head.wdata       : '0;
        blitw_sdram_byte_enable = not_empty ? head.byte_enable : '0;
    end

endmodule

// File: tb/tb_blit_write_buffer.sv
// Self-checking bench for blit_write_buffer: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_blit_write_buffer;
    import blit_pkg::*;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [25:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [3:0]  in_byte_enable = '0;
    logic        pending;
    logic        blitw_sdram_req;
    logic [25:0] blitw_sdram_addr;
    logic [31:0] blitw_sdram_wdata;
    logic [3:0]  blitw_sdram_byte_enable;
    logic        blitw_sdram_ack = 1'b0;

    blit_write_buffer #(.DEPTH(DEPTH)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_addr                 (in_addr),
        .in_wdata                (in_wdata),
        .in_byte_enable          (in_byte_enable),
        .pending                 (pending),
        .blitw_sdram_req         (blitw_sdram_req),
        .blitw_sdram_addr        (blitw_sdram_addr),
        .blitw_sdram_wdata       (blitw_sdram_wdata),
        .blitw_sdram_byte_enable (blitw_sdram_byte_enable),
        .blitw_sdram_ack         (blitw_sdram_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [25:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t mq[$];
    bit   m_ready_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

`ifdef BLIT_WRITE_BUFFER_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_merge(input logic [25:0] a);
        return MERGE && (mq.size() >= 2) && (mq[mq.size()-1].a == a);
    endfunction

    function automatic bit model_ready(input logic [25:0] a);
        return m_ready_en && ((mq.size() < DEPTH) || model_merge(a));
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic cyc(input logic v, input logic [25:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic ack);
        bit   acc;
        bit   mrg;
        ent_t e;
        logic [31:0] mask;
        in_valid        = v;
        in_addr         = a;
        in_wdata        = d;
        in_byte_enable  = be;
        blitw_sdram_ack = ack;
        #1;
        check("in_ready", in_ready, model_ready(a));
        check("req", blitw_sdram_req, mq.size() != 0);
        check("pending", pending, mq.size() != 0);
        if (mq.size() != 0) begin
            check("head_addr", blitw_sdram_addr, mq[0].a);
            check("head_data", blitw_sdram_wdata, mq[0].d);
            check("head_be", blitw_sdram_byte_enable, mq[0].be);
        end
        acc = v && model_ready(a) && (be != 4'b0000);
        mrg = acc && model_merge(a);
        if (mrg) begin
            e = mq[mq.size()-1];
            mask = '0;
            for (int n = 0; n < 4; n++) if (be[n]) mask[8*n +: 8] = 8'hFF;
            e.d  = (e.d & ~mask) | (d & mask);
            e.be = e.be | be;
            mq[mq.size()-1] = e;
        end
        if (ack && mq.size() != 0) void'(mq.pop_front());
        if (acc && !mrg) begin
            e.a = a; e.d = d; e.be = be;
            mq.push_back(e);
        end
        @(posedge clock);
        #1;
        m_ready_en = 1'b1;
    endtask

    task automatic idle(input logic ack);
        cyc(1'b0, '0, '0, 4'h0, ack);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && mq.size() != 0; i++) idle(1'b1);
        check("drained", mq.size(), 0);
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        check("rst_ready", in_ready, 1'b0);
        check("rst_req", blitw_sdram_req, 1'b0);
        check("rst_pending", pending, 1'b0);
        check("rst_addr", blitw_sdram_addr, 26'h0);
        check("rst_data", blitw_sdram_wdata, 32'h0);
        check("rst_be", blitw_sdram_byte_enable, 4'h0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        idle(1'b0);
        check("ready_after_release", in_ready, 1'b1);

        // Single push, ack held low: req from next cycle, fields stable
        cyc(1'b1, 26'h0000100, 32'hDEADBEEF, 4'hF, 1'b0);
        check("push_req_n1", blitw_sdram_req, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b0);
        check("hold_addr", blitw_sdram_addr, 26'h0000100);
        check("hold_data", blitw_sdram_wdata, 32'hDEADBEEF);
        drain();

        // Fill past depth: ninth write stalls until one ack
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 26'(32'h200 + i), 32'hA0000000 + i, 4'hF, 1'b0);
        check("full_ready", in_ready, 1'b0);
        cyc(1'b1, 26'h0000208, 32'hA0000008, 4'hF, 1'b0);
        cyc(1'b1, 26'h0000208, 32'hA0000008, 4'hF, 1'b1);
        check("ready_after_pop", in_ready, 1'b1);
        cyc(1'b1, 26'h0000208, 32'hA0000008, 4'hF, 1'b0);
        check("ninth_held", mq.size(), DEPTH);
        drain();

        // Zero byte-enable write is dropped
        cyc(1'b1, 26'h0000300, 32'h12345678, 4'h0, 1'b0);
        idle(1'b0);
        check("be0_pending", pending, 1'b0);

        // Ack while empty is ignored; next push presented correctly
        idle(1'b1); idle(1'b1);
        cyc(1'b1, 26'h0000400, 32'hCAFEF00D, 4'h6, 1'b0);
        check("post_ack_addr", blitw_sdram_addr, 26'h0000400);
        check("post_ack_be", blitw_sdram_byte_enable, 4'h6);
        drain();

        // Merge sequence
        cyc(1'b1, 26'h10, 32'h00001111, 4'h3, 1'b0);
        cyc(1'b1, 26'h20, 32'h000000AA, 4'h1, 1'b0);
        cyc(1'b1, 26'h20, 32'h00BB0000, 4'h4, 1'b0);
        idle(1'b1);
        check("m2_addr", blitw_sdram_addr, 26'h20);
        check("m2_be", blitw_sdram_byte_enable, MERGE ? 4'h5 : 4'h1);
        check("m2_data", blitw_sdram_wdata, MERGE ? 32'h00BB00AA : 32'h000000AA);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            if (blitw_sdram_req) n++;
            idle(1'b1);
        end
        check("merge_entries", n, MERGE ? 2 : 3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 3) != 0),
                26'(32'h10 * $urandom_range(1, 3)),
                $urandom,
                4'($urandom_range(0, 15)),
                1'($urandom_range(0, 2) == 0));
        end
        drain();

        // Reset in the middle of an ack with three entries buffered
        for (int i = 0; i < 3; i++) cyc(1'b1, 26'(32'h500 + i), 32'hB0000000 + i, 4'hF, 1'b0);
        in_valid = 1'b0;
        blitw_sdram_ack = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req", blitw_sdram_req, 1'b0);
        check("mid_rst_pending", pending, 1'b0);
        check("mid_rst_ready", in_ready, 1'b0);
        check("mid_rst_addr", blitw_sdram_addr, 26'h0);
        mq.delete();
        m_ready_en = 1'b0;
        blitw_sdram_ack = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        idle(1'b0);
        check("post_rst_ready", in_ready, 1'b1);
        idle(1'b0);
        check("post_rst_no_stale", blitw_sdram_req, 1'b0);
        cyc(1'b1, 26'h0000600, 32'h55AA55AA, 4'h9, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
